hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the LC-3b five-stage datapath, sitting beside the IF/ID and ID/EX pipeline registers. It detects load-use hazards and control-flow instructions and issues bubbles, IF holds and ID squashes. It supports a configurable load-use bubble count, a configurable branch-shadow depth, early release of the shadow on a resolved not-taken branch, and a global memory-stall freeze.

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the LC-3b five-stage datapath.
// Detects load-use hazards between ID/EX and IF/ID, and shadows control-flow
// instructions with bubbles followed by an optional IF/ID squash. A memory stall
// freezes the whole pipeline and this controller's state.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_if_id_ir      instruction held in IF/ID
//   i_id_ex_ir      instruction held in ID/EX
//   i_br_resolve    pulse: the BR in flight resolved this cycle
//   i_br_taken      resolved outcome, valid with i_br_resolve
//   i_mem_stall     level: MEM stage has not completed
//   o_gen_bubble    insert NOP into ID/EX this cycle
//   o_stall_if      hold PC and IF/ID this cycle
//   o_squash_id     replace IF/ID with NOP at the next edge
//   o_stall_all     freeze every pipeline register
//   o_busy          controller is not idle
module hazard_ctrl #(
  parameter int unsigned SHADOW_DEPTH = 5,
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned EARLY_NT     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_if_id_ir,
  input  logic [15:0] i_id_ex_ir,
  input  logic        i_br_resolve,
  input  logic        i_br_taken,
  input  logic        i_mem_stall,
  output logic        o_gen_bubble,
  output logic        o_stall_if,
  output logic        o_squash_id,
  output logic        o_stall_all,
  output logic        o_busy
);

  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLdb  = 4'b0010;
  localparam logic [3:0] OpStb  = 4'b0011;
  localparam logic [3:0] OpJsr  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpLdr  = 4'b0110;
  localparam logic [3:0] OpStr  = 4'b0111;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpLdi  = 4'b1010;
  localparam logic [3:0] OpSti  = 4'b1011;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpTrap = 4'b1111;

  typedef enum logic [1:0] {StIdle, StLoadStall, StShadow} state_e;

  state_e     r_state;
  logic [2:0] r_cnt;
  logic       r_is_br;
  logic       r_taken_q;

  logic [3:0] w_if_op;
  logic [3:0] w_ex_op;
  logic [2:0] w_ex_dest;
  logic       w_ex_load;
  logic       w_if_load;
  logic       w_if_store;
  logic       w_use_sr1;
  logic       w_use_sr2;
  logic       w_hazard;
  logic       w_ctrl;
  logic       w_early;
  logic       w_unused_ex;

  assign w_if_op   = i_if_id_ir[15:12];
  assign w_ex_op   = i_id_ex_ir[15:12];
  assign w_ex_dest = i_id_ex_ir[11:9];

  // Only the opcode and destination of the ID/EX instruction matter here.
  assign w_unused_ex = ^i_id_ex_ir[8:0];

  assign w_ex_load  = w_ex_op inside {OpLdb, OpLdi, OpLdr};
  assign w_if_load  = w_if_op inside {OpLdb, OpLdi, OpLdr};
  assign w_if_store = w_if_op inside {OpStb, OpSti, OpStr};

  // JSR with ir[11]=0 is JSRR, which reads its base register from [8:6].
  assign w_use_sr1 = (w_if_op inside {OpAdd, OpAnd, OpNot, OpJmp}) | w_if_load | w_if_store |
                     ((w_if_op == OpJsr) & ~i_if_id_ir[11]);
  assign w_use_sr2 = (w_if_op inside {OpAdd, OpAnd}) & ~i_if_id_ir[5];

  assign w_hazard = w_ex_load & ((w_use_sr1  & (i_if_id_ir[8:6]  == w_ex_dest)) |
                                 (w_use_sr2  & (i_if_id_ir[2:0]  == w_ex_dest)) |
                                 (w_if_store & (i_if_id_ir[11:9] == w_ex_dest)));

  // An all-zero word is the pipeline NOP (BR with no condition bits), not a branch.
  assign w_ctrl = (w_if_op inside {OpBr, OpJmp, OpJsr, OpTrap}) & (i_if_id_ir != 16'h0000);

  assign w_early = (EARLY_NT != 0) & r_is_br & i_br_resolve & ~i_br_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= 3'd0;
      r_is_br   <= 1'b0;
      r_taken_q <= 1'b0;
    end else if (!i_mem_stall) begin
      case (r_state)
        StIdle: begin
          if (w_hazard) begin
            if (LOAD_BUBBLES > 1) begin
              r_state <= StLoadStall;
              r_cnt   <= 3'(LOAD_BUBBLES - 1);
            end
          end else if (w_ctrl) begin
            r_state   <= StShadow;
            r_cnt     <= 3'(SHADOW_DEPTH);
            r_is_br   <= (w_if_op == OpBr);
            r_taken_q <= 1'b0;
          end
        end
        StLoadStall: begin
          if (r_cnt <= 3'd1) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        StShadow: begin
          if (w_early) begin
            r_state <= StIdle;
            r_cnt   <= 3'd0;
          end else begin
            if (i_br_resolve) begin
              r_taken_q <= i_br_taken;
            end
            if (r_cnt > 3'd1) begin
              r_cnt <= r_cnt - 3'd1;
            end else begin
              r_state <= StIdle;
              r_cnt   <= 3'd0;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  // Mealy outputs; everything is held low while reset is asserted.
  always_comb begin
    o_gen_bubble = 1'b0;
    o_stall_if   = 1'b0;
    o_squash_id  = 1'b0;
    o_stall_all  = 1'b0;
    if (rst_n) begin
      if (i_mem_stall) begin
        o_stall_all = 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            o_gen_bubble = w_hazard;
            o_stall_if   = w_hazard;
          end
          StLoadStall: begin
            o_gen_bubble = 1'b1;
            o_stall_if   = 1'b1;
          end
          StShadow: begin
            if (!w_early) begin
              if (r_cnt > 3'd1) begin
                o_gen_bubble = 1'b1;
              end else begin
                o_squash_id = ~r_is_br | r_taken_q;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_busy = rst_n & (r_state != StIdle);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Two instances share stimulus:
//   u_dut0: SHADOW_DEPTH=5, LOAD_BUBBLES=3, EARLY_NT=1
//   u_dut1: SHADOW_DEPTH=2, LOAD_BUBBLES=1, EARLY_NT=0
// Output vectors are compared as {gen_bubble, stall_if, squash_id, stall_all, busy}.
module tb_hazard_ctrl;

  localparam logic [15:0] NOP     = 16'h0000;
  localparam logic [15:0] LDR_R2  = 16'h6540;  // LDR R2, R5, #0
  localparam logic [15:0] ADD_R23 = 16'h1283;  // ADD R1, R2, R3
  localparam logic [15:0] TRAP    = 16'hF025;
  localparam logic [15:0] BR      = 16'h0E05;  // BRnzp

  logic        clk;
  logic        rst_n;
  logic [15:0] if_id_ir;
  logic [15:0] id_ex_ir;
  logic        br_resolve;
  logic        br_taken;
  logic        mem_stall;
  logic        gb0, si0, sq0, sa0, busy0;
  logic        gb1, si1, sq1, sa1, busy1;
  logic [4:0]  obs0;
  logic [4:0]  obs1;

  int n_checks = 0;
  int n_fail   = 0;

  assign obs0 = {gb0, si0, sq0, sa0, busy0};
  assign obs1 = {gb1, si1, sq1, sa1, busy1};

  hazard_ctrl #(.SHADOW_DEPTH(5), .LOAD_BUBBLES(3), .EARLY_NT(1)) u_dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_if_id_ir   (if_id_ir),
    .i_id_ex_ir   (id_ex_ir),
    .i_br_resolve (br_resolve),
    .i_br_taken   (br_taken),
    .i_mem_stall  (mem_stall),
    .o_gen_bubble (gb0),
    .o_stall_if   (si0),
    .o_squash_id  (sq0),
    .o_stall_all  (sa0),
    .o_busy       (busy0)
  );

  hazard_ctrl #(.SHADOW_DEPTH(2), .LOAD_BUBBLES(1), .EARLY_NT(0)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_if_id_ir   (if_id_ir),
    .i_id_ex_ir   (id_ex_ir),
    .i_br_resolve (br_resolve),
    .i_br_taken   (br_taken),
    .i_mem_stall  (mem_stall),
    .o_gen_bubble (gb1),
    .o_stall_if   (si1),
    .o_squash_id  (sq1),
    .o_stall_all  (sa1),
    .o_busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] ifid, input logic [15:0] idex, input logic res,
                       input logic tk, input logic ms);
    if_id_ir   = ifid;
    id_ex_ir   = idex;
    br_resolve = res;
    br_taken   = tk;
    mem_stall  = ms;
    #1;
  endtask

  task automatic next_cycle;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(ADD_R23, LDR_R2, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs0 !== 5'b00000) begin
      n_fail++; $display("FAIL reset_dut0: got %b want %b", obs0, 5'b00000);
    end
    n_checks++;
    if (obs1 !== 5'b00000) begin
      n_fail++; $display("FAIL reset_dut1: got %b want %b", obs1, 5'b00000);
    end
    next_cycle();
    rst_n = 1'b1;
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs0 !== 5'b00000 || u_dut0.r_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_release: got %b cnt %0d want 00000 cnt 0", obs0, u_dut0.r_cnt);
    end
    n_checks++;
    if (obs1 !== 5'b00000) begin
      n_fail++; $display("FAIL reset_release_dut1: got %b want %b", obs1, 5'b00000);
    end
    next_cycle();
  endtask

  task automatic test_load_use;
    logic [15:0] idex_v [4] = '{LDR_R2, NOP, NOP, NOP};
    logic [4:0]  exp0   [4] = '{5'b11000, 5'b11001, 5'b11001, 5'b00000};
    logic [4:0]  exp1   [4] = '{5'b11000, 5'b00000, 5'b00000, 5'b00000};
    for (int c = 0; c < 4; c++) begin
      drive(ADD_R23, idex_v[c], 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs0 !== exp0[c]) begin
        n_fail++; $display("FAIL load_use_dut0 c%0d: got %b want %b", c, obs0, exp0[c]);
      end
      n_checks++;
      if (obs1 !== exp1[c]) begin
        n_fail++; $display("FAIL load_use_dut1 c%0d: got %b want %b", c, obs1, exp1[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_hazard_decode;
    logic [15:0] idex_v [11] = '{16'h6540, 16'h6540, 16'h6540, 16'h6540, 16'h6540, 16'h6540,
                                 16'h2540, 16'hA540, 16'h6940, 16'h1483, 16'h6540};
    logic [15:0] ifid_v [11] = '{16'h12C2, 16'h12E2, 16'h74C0, 16'hC080, 16'h4080, 16'h4880,
                                 16'h1283, 16'h1283, 16'h1283, 16'h1283, 16'h92BF};
    logic        haz_v  [11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int v = 0; v < 11; v++) begin
      drive(ifid_v[v], idex_v[v], 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({gb0, si0} !== {haz_v[v], haz_v[v]}) begin
        n_fail++; $display("FAIL decode_dut0 v%0d: got %b%b want %b%b", v, gb0, si0, haz_v[v],
                           haz_v[v]);
      end
      n_checks++;
      if ({gb1, si1} !== {haz_v[v], haz_v[v]}) begin
        n_fail++; $display("FAIL decode_dut1 v%0d: got %b%b want %b%b", v, gb1, si1, haz_v[v],
                           haz_v[v]);
      end
      for (int d = 0; d < 6; d++) begin
        next_cycle();
        drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
      end
      next_cycle();
    end
  endtask

  task automatic test_trap_shadow;
    logic [4:0] exp0 [7] = '{5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b00101,
                             5'b00000};
    logic [4:0] exp1 [7] = '{5'b00000, 5'b10001, 5'b00101, 5'b00000, 5'b00000, 5'b00000,
                             5'b00000};
    for (int c = 0; c < 7; c++) begin
      drive((c == 0) ? TRAP : NOP, NOP, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs0 !== exp0[c]) begin
        n_fail++; $display("FAIL trap_shadow_dut0 c%0d: got %b want %b", c, obs0, exp0[c]);
      end
      n_checks++;
      if (obs1 !== exp1[c]) begin
        n_fail++; $display("FAIL trap_shadow_dut1 c%0d: got %b want %b", c, obs1, exp1[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_br_taken;
    logic       res_v [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0] exp0  [7] = '{5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b00101,
                              5'b00000};
    logic [4:0] exp1  [7] = '{5'b00000, 5'b10001, 5'b00001, 5'b00000, 5'b00000, 5'b00000,
                              5'b00000};
    for (int c = 0; c < 7; c++) begin
      drive((c == 0) ? BR : NOP, NOP, res_v[c], res_v[c], 1'b0);
      n_checks++;
      if (obs0 !== exp0[c]) begin
        n_fail++; $display("FAIL br_taken_dut0 c%0d: got %b want %b", c, obs0, exp0[c]);
      end
      n_checks++;
      if (obs1 !== exp1[c]) begin
        n_fail++; $display("FAIL br_taken_dut1 c%0d: got %b want %b", c, obs1, exp1[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_br_not_taken;
    logic       res_v [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0] exp0  [5] = '{5'b00000, 5'b10001, 5'b00001, 5'b00000, 5'b00000};
    logic [4:0] exp1  [5] = '{5'b00000, 5'b10001, 5'b00001, 5'b00000, 5'b00000};
    for (int c = 0; c < 5; c++) begin
      drive((c == 0) ? BR : NOP, NOP, res_v[c], 1'b0, 1'b0);
      n_checks++;
      if (obs0 !== exp0[c]) begin
        n_fail++; $display("FAIL br_not_taken_dut0 c%0d: got %b want %b", c, obs0, exp0[c]);
      end
      n_checks++;
      if (obs1 !== exp1[c]) begin
        n_fail++; $display("FAIL br_not_taken_dut1 c%0d: got %b want %b", c, obs1, exp1[c]);
      end
      if (c == 3) begin
        n_checks++;
        if (u_dut0.r_cnt !== 3'd0) begin
          n_fail++; $display("FAIL early_cnt_clear: got %0d want 0", u_dut0.r_cnt);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mem_stall;
    logic [15:0] idex_v [8] = '{LDR_R2, NOP, NOP, NOP, NOP, NOP, NOP, NOP};
    logic        ms_v   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        tk_v   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0]  exp0   [8] = '{5'b11000, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b11001,
                                5'b11001, 5'b00000};
    logic [4:0]  exp1   [8] = '{5'b11000, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000,
                                5'b00000, 5'b00000};
    for (int c = 0; c < 8; c++) begin
      drive(ADD_R23, idex_v[c], ms_v[c], tk_v[c], ms_v[c]);
      n_checks++;
      if (obs0 !== exp0[c]) begin
        n_fail++; $display("FAIL mem_stall_dut0 c%0d: got %b want %b", c, obs0, exp0[c]);
      end
      n_checks++;
      if (obs1 !== exp1[c]) begin
        n_fail++; $display("FAIL mem_stall_dut1 c%0d: got %b want %b", c, obs1, exp1[c]);
      end
      if (ms_v[c]) begin
        n_checks++;
        if (u_dut0.r_cnt !== 3'd2) begin
          n_fail++; $display("FAIL mem_stall_cnt c%0d: got %0d want 2", c, u_dut0.r_cnt);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall_shadow;
    logic       ms_v [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       tk_v [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [4:0] exp0 [9] = '{5'b00000, 5'b10001, 5'b00011, 5'b00011, 5'b10001, 5'b10001,
                             5'b10001, 5'b00001, 5'b00000};
    logic [4:0] exp1 [9] = '{5'b00000, 5'b10001, 5'b00011, 5'b00011, 5'b00001, 5'b00000,
                             5'b00000, 5'b00000, 5'b00000};
    for (int c = 0; c < 9; c++) begin
      // br_resolve pulses only while stalled, so it must be ignored.
      drive((c == 0) ? BR : NOP, NOP, ms_v[c], tk_v[c], ms_v[c]);
      n_checks++;
      if (obs0 !== exp0[c]) begin
        n_fail++; $display("FAIL stall_shadow_dut0 c%0d: got %b want %b", c, obs0, exp0[c]);
      end
      n_checks++;
      if (obs1 !== exp1[c]) begin
        n_fail++; $display("FAIL stall_shadow_dut1 c%0d: got %b want %b", c, obs1, exp1[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_shadow;
    logic [4:0] exp0 [4] = '{5'b00000, 5'b10001, 5'b10001, 5'b10001};
    for (int c = 0; c < 4; c++) begin
      drive((c == 0) ? TRAP : NOP, NOP, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (obs0 !== exp0[c]) begin
        n_fail++; $display("FAIL rst_shadow_pre c%0d: got %b want %b", c, obs0, exp0[c]);
      end
      if (c < 3) next_cycle();
    end
    n_checks++;
    if (u_dut0.r_cnt !== 3'd3) begin
      n_fail++; $display("FAIL rst_shadow_cnt3: got %0d want 3", u_dut0.r_cnt);
    end
    rst_n = 1'b0;
    drive(ADD_R23, LDR_R2, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (obs0 !== 5'b00000 || u_dut0.r_cnt !== 3'd0) begin
      n_fail++; $display("FAIL rst_shadow_async: got %b cnt %0d want 00000 cnt 0", obs0,
                         u_dut0.r_cnt);
    end
    n_checks++;
    if (obs1 !== 5'b00000) begin
      n_fail++; $display("FAIL rst_shadow_dut1: got %b want %b", obs1, 5'b00000);
    end
    next_cycle();
    rst_n = 1'b1;
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (obs0 !== 5'b00000 || u_dut0.r_cnt !== 3'd0) begin
      n_fail++; $display("FAIL rst_shadow_after: got %b cnt %0d want 00000 cnt 0", obs0,
                         u_dut0.r_cnt);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hazard_decode();
    test_trap_shadow();
    test_br_taken();
    test_br_not_taken();
    test_mem_stall();
    test_stall_shadow();
    test_reset_mid_shadow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
